// File: rtl/vga_rom_arbiter.sv
// Two-port read arbiter in front of a shared single-port ROM (one-cycle read latency).
// Port 0 (pixel fetch) has priority; port 1 wins once it has been denied STARVE_MAX cycles.
module vga_rom_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        r0_req,
   input  logic [10:0] r0_addr,
   output logic        r0_gnt,
   output logic        r0_valid,
   output logic [7:0]  r0_data,
   input  logic        r1_req,
   input  logic [10:0] r1_addr,
   output logic        r1_gnt,
   output logic        r1_valid,
   output logic [7:0]  r1_data,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data
);

   localparam int AW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [AW-1:0] AGE_MAX = AW'(STARVE_MAX);

   logic [AW-1:0] r_age1;
   logic          r_s2_v;
   logic          r_s2_id;

   logic w_elig0;
   logic w_elig1;
   logic w_sel_v;
   logic w_sel_id;

   // A port is never re-arbitrated in its own grant cycle.
   assign w_elig0  = r0_req & ~r0_gnt;
   assign w_elig1  = r1_req & ~r1_gnt;
   assign w_sel_v  = w_elig0 | w_elig1;
   assign w_sel_id = w_elig1 & (~w_elig0 | (r_age1 == AGE_MAX));

   // The grant registers double as the first owner stage (ROM address cycle).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r0_gnt   <= 1'b0;
         r1_gnt   <= 1'b0;
         rom_addr <= 11'd0;
         r_s2_v   <= 1'b0;
         r_s2_id  <= 1'b0;
         r0_valid <= 1'b0;
         r1_valid <= 1'b0;
         r0_data  <= 8'h00;
         r1_data  <= 8'h00;
      end else begin
         r0_gnt   <= w_sel_v & ~w_sel_id;
         r1_gnt   <= w_sel_v & w_sel_id;
         if (w_sel_v) begin
            rom_addr <= w_sel_id ? r1_addr : r0_addr;
         end
         r_s2_v   <= r0_gnt | r1_gnt;
         r_s2_id  <= r1_gnt;
         r0_valid <= r_s2_v & ~r_s2_id;
         r1_valid <= r_s2_v & r_s2_id;
         if (r_s2_v && !r_s2_id) begin
            r0_data <= rom_data;
         end
         if (r_s2_v && r_s2_id) begin
            r1_data <= rom_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_age1 <= '0;
      end else if (w_sel_v && w_sel_id) begin
         r_age1 <= '0;
      end else if (w_elig1 && (r_age1 != AGE_MAX)) begin
         r_age1 <= r_age1 + 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_rom_arbiter.sv
// Bench for vga_rom_arbiter: event-schedule reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vga_rom_arbiter;
   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        r0_req, r1_req;
   logic [10:0] r0_addr, r1_addr;
   logic        r0_gnt, r1_gnt, r0_valid, r1_valid;
   logic [7:0]  r0_data, r1_data;
   logic [10:0] rom_addr;
   logic [7:0]  rom_data;

   logic [7:0]  rom [0:2047];

   always #5 clk = ~clk;

   vga_rom_arbiter #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_addr(r0_addr), .r0_gnt(r0_gnt),
      .r0_valid(r0_valid), .r0_data(r0_data),
      .r1_req(r1_req), .r1_addr(r1_addr), .r1_gnt(r1_gnt),
      .r1_valid(r1_valid), .r1_data(r1_data),
      .rom_addr(rom_addr), .rom_data(rom_data)
   );

   always @(posedge clk) rom_data <= rom[rom_addr];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: each selection schedules a grant one cycle ahead and a
   // data return three cycles ahead into an 8-entry cycle-indexed calendar.
   bit          e_g0 [8];
   bit          e_g1 [8];
   bit          e_v0 [8];
   bit          e_v1 [8];
   logic [10:0] e_a  [8];
   logic [7:0]  e_d0 [8];
   logic [7:0]  e_d1 [8];
   int          m_age = 0;
   int          mc = 0;
   logic [10:0] m_ra = '0;
   logic [7:0]  m_d0 = '0;
   logic [7:0]  m_d1 = '0;

   always @(negedge clk) begin
      int s, n1, n3, p;
      bit el0, el1;
      s  = mc % 8;
      n1 = (mc + 1) % 8;
      n3 = (mc + 3) % 8;
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) begin
            e_g0[i] = 0; e_g1[i] = 0; e_v0[i] = 0; e_v1[i] = 0;
         end
         m_age = 0; m_ra = '0; m_d0 = '0; m_d1 = '0;
         chk("reset_outputs", {r0_gnt, r1_gnt, r0_valid, r1_valid, r0_data, r1_data, rom_addr},
             32'd0);
      end else begin
         if (e_g0[s] || e_g1[s]) m_ra = e_a[s];
         if (e_v0[s]) m_d0 = e_d0[s];
         if (e_v1[s]) m_d1 = e_d1[s];
         chk("r0_gnt", r0_gnt, e_g0[s]);
         chk("r1_gnt", r1_gnt, e_g1[s]);
         chk("rom_addr", rom_addr, m_ra);
         chk("r0_valid", r0_valid, e_v0[s]);
         chk("r1_valid", r1_valid, e_v1[s]);
         chk("r0_data", r0_data, m_d0);
         chk("r1_data", r1_data, m_d1);
         chk("gnt_exclusive", r0_gnt & r1_gnt, 0);
         chk("valid_exclusive", r0_valid & r1_valid, 0);
         el0 = r0_req && !e_g0[s];
         el1 = r1_req && !e_g1[s];
         if (el0 && el1) p = (m_age == SM) ? 1 : 0;
         else if (el0)   p = 0;
         else if (el1)   p = 1;
         else            p = -1;
         if (p == 1) m_age = 0;
         else if (el1 && m_age < SM) m_age = m_age + 1;
         if (p == 0) begin
            e_g0[n1] = 1; e_a[n1] = r0_addr; e_v0[n3] = 1; e_d0[n3] = rom[r0_addr];
         end else if (p == 1) begin
            e_g1[n1] = 1; e_a[n1] = r1_addr; e_v1[n3] = 1; e_d1[n3] = rom[r1_addr];
         end
         e_g0[s] = 0; e_g1[s] = 0; e_v0[s] = 0; e_v1[s] = 0;
      end
      mc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      r0_req = 0; r1_req = 0;
      repeat (n) tick();
   endtask

   initial begin
      rst_n = 0; r0_req = 0; r1_req = 0; r0_addr = '0; r1_addr = '0;
      for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom);
      rom[11'h155] = 8'hA5;
      rom[11'h010] = 8'h3C;
      rom[11'h020] = 8'hC3;
      rom[11'h3FF] = 8'h5A;
      repeat (2) tick();
      rst_n = 1;
      idle(2);

      // Single read on port 1
      r1_req = 1; r1_addr = 11'h155;
      tick(); r1_req = 0;
      @(negedge clk);
      chk("single_r1_gnt", r1_gnt, 1);
      chk("single_rom_addr", rom_addr, 11'h155);
      tick(); tick();
      @(negedge clk);
      chk("single_r1_valid", r1_valid, 1);
      chk("single_r1_data", r1_data, 8'hA5);
      idle(4);

      // Alternating back-to-back
      r0_req = 1; r0_addr = 11'h010;
      tick(); r0_req = 0; r1_req = 1; r1_addr = 11'h020;
      tick(); r1_req = 0;
      tick();
      @(negedge clk);
      chk("alt_r0_valid", r0_valid, 1);
      chk("alt_r0_data", r0_data, 8'h3C);
      tick();
      @(negedge clk);
      chk("alt_r1_valid", r1_valid, 1);
      chk("alt_r1_data", r1_data, 8'hC3);
      idle(4);

      // Contention: both held high, grants alternate starting with port 0
      r0_req = 1; r1_req = 1; r0_addr = 11'h011; r1_addr = 11'h022;
      for (int k = 1; k <= 8; k++) begin
         tick();
         @(negedge clk);
         chk("contend_r0_gnt", r0_gnt, k % 2);
         chk("contend_r1_gnt", r1_gnt, (k + 1) % 2);
      end
      idle(5);

      // Pixel cadence: port 0 every 4th cycle, port 1 always requesting
      r1_req = 1;
      for (int i = 0; i < 24; i++) begin
         r0_req = (i % 4 == 0);
         r0_addr = 11'(i * 7);
         r1_addr = 11'(i + 100);
         @(negedge clk);
         chk("cadence_r0_valid", r0_valid, (i >= 3 && (i - 3) % 4 == 0));
         tick();
      end
      idle(5);

      // Reset during flight
      r0_req = 1; r0_addr = 11'h010;
      tick(); r0_req = 0;
      @(negedge clk);
      chk("flight_r0_gnt", r0_gnt, 1);
      tick(); rst_n = 0;
      #1;
      chk("flight_reset_now", {r0_gnt, r1_gnt, r0_valid, r1_valid, r0_data, r1_data, rom_addr},
          32'd0);
      tick(); rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("flight_no_valid", r0_valid, 0);
         tick();
      end

      // Idle hold after a read of 3FF
      r0_req = 1; r0_addr = 11'h3FF;
      tick(); r0_req = 0;
      repeat (3) tick();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_rom_addr", rom_addr, 11'h3FF);
         chk("idle_pulses", {r0_gnt, r1_gnt, r0_valid, r1_valid}, 0);
         tick();
      end

      // Randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 499) == 0) begin
            rst_n = 0;
            tick();
            rst_n = 1;
         end
         if (!r0_req || r0_gnt) begin
            r0_req = ($urandom_range(0, 3) != 0);
            r0_addr = 11'($urandom);
         end
         if (!r1_req || r1_gnt) begin
            r1_req = ($urandom_range(0, 2) != 0);
            r1_addr = 11'($urandom);
         end
         tick();
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
